// File: rtl/sobel_pad_streamer.sv
// sobel_pad_streamer: buffers raw pixels in a FIFO and emits a gap-free zero-padded raster for the Sobel stage.
// Optional SOBEL_PAD_UNDERRUN_EN adds a sticky underrun flag and a 16-bit saturating underrun counter.
module sobel_pad_streamer #(
   parameter int IMG_W      = 480,
   parameter int IMG_H      = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] pix_out,
   output logic       start,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;
   localparam int CW = $clog2(IMG_W + 2);
   localparam int RW = $clog2(IMG_H + 2);
   localparam int P  = (FIFO_DEPTH < IMG_W * IMG_H) ? FIFO_DEPTH : IMG_W * IMG_H;
   localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);
   localparam logic [NW-1:0] PRIME_CNT = NW'(P);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W + 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H + 1);

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          flush_cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count, count_n;
   logic          last_col, last_row, pop_pos, pop, push, fill_now, fill_next;

   always_comb begin
      last_col  = col == COL_LAST;
      last_row  = row == ROW_LAST;
      pop_pos   = state == STREAM && row != '0 && !last_row && col != '0 && !last_col;
      pop       = pop_pos && count != '0;
      push      = in_valid && in_ready;
      count_n   = count + NW'(push) - NW'(pop);
      state_n   = IDLE;
      case (state)
         IDLE:    state_n = frame_start ? PRIME : IDLE;
         PRIME:   state_n = count == PRIME_CNT ? STREAM : PRIME;
         STREAM:  state_n = last_row && last_col ? FLUSH : STREAM;
         FLUSH:   state_n = flush_cnt ? DONE : FLUSH;
         default: state_n = IDLE;
      endcase
      fill_now  = state == PRIME || state == STREAM;
      fill_next = state_n == PRIME || state_n == STREAM;
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         flush_cnt  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pix_out    <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         state      <= state_n;
         busy       <= state != IDLE && state_n != IDLE;
         in_ready   <= fill_now && fill_next && count_n != FULL;
         start      <= state == STREAM || state == FLUSH;
         pix_out    <= pop ? mem[rd_ptr] : '0;
         frame_done <= state == DONE;
         flush_cnt  <= state == FLUSH && !flush_cnt;
         if (state == IDLE && frame_start) begin
            row <= '0;
            col <= '0;
         end else if (state == STREAM) begin
            col <= last_col ? '0 : col + CW'(1);
            row <= last_col ? row + RW'(1) : row;
         end
         // leftover input beyond the frame is discarded so the next frame starts clean
         if (state == DONE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_n;
         end
      end
   end

`ifdef SOBEL_PAD_UNDERRUN_EN
   logic [15:0] underrun_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (state == IDLE && frame_start) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (pop_pos && count == '0) begin
         underrun     <= 1'b1;
         underrun_cnt <= underrun_cnt + {15'd0, underrun_cnt != 16'hffff};
      end
   end
`else
   assign underrun = 1'b0;
`endif
endmodule
